// File: rtl/reg_write_sched_if.sv
// Bus bundle for the write-back scheduler: requester handshake on one side,
// register-file write ports, PC update port and stall counter on the other.
interface reg_write_sched_if #(
   parameter int N     = 32,
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
);
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_addr;
   logic [N*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;

   logic              wr_en_1;
   logic [3:0]        wr_addr_1;
   logic [N-1:0]      wr_data_1;
   logic              wr_en_2;
   logic [3:0]        wr_addr_2;
   logic [N-1:0]      wr_data_2;
   logic              pc_write;
   logic [N-1:0]      pc_update;
   logic [CNT_W-1:0]  stall_cnt;

   // Requester / observer side
   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready,
      input  wr_en_1, wr_addr_1, wr_data_1,
      input  wr_en_2, wr_addr_2, wr_data_2,
      input  pc_write, pc_update, stall_cnt
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready,
      output wr_en_1, wr_addr_1, wr_data_1,
      output wr_en_2, wr_addr_2, wr_data_2,
      output pc_write, pc_update, stall_cnt
   );
endinterface

// File: rtl/reg_write_sched.sv
// Write-back scheduler for a 16x32 register file. Four requesters share two
// general write ports and a dedicated PC (R15) port. Grants are computed
// combinationally in round-robin order; granted writes are registered and
// driven on the register-file ports one cycle later. Two writes to the same
// register in one cycle are never both granted: the later one in scan order
// waits a cycle so that it lands last.
module reg_write_sched #(
   parameter int N     = 32,
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   reg_write_sched_if.slave bus
);

   localparam logic [3:0] PC_ADDR = 4'd15;

   // Per-requester views of the packed request buses
   logic [3:0]   addr_a [NREQ];
   logic [N-1:0] data_a [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_a[gi] = bus.req_addr[4*gi +: 4];
         assign data_a[gi] = bus.req_data[N*gi +: N];
      end
   endgenerate

   // State
   logic [1:0]       rr_ptr_q,    rr_ptr_d;
   logic             wr_en_1_q,   wr_en_1_d;
   logic [3:0]       wr_addr_1_q, wr_addr_1_d;
   logic [N-1:0]     wr_data_1_q, wr_data_1_d;
   logic             wr_en_2_q,   wr_en_2_d;
   logic [3:0]       wr_addr_2_q, wr_addr_2_d;
   logic [N-1:0]     wr_data_2_q, wr_data_2_d;
   logic             pc_write_q,  pc_write_d;
   logic [N-1:0]     pc_update_q, pc_update_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Grant-scan results
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] req_ready;
   logic [1:0]      sel_1, sel_2, sel_pc;
   logic            use_1, use_2, use_pc;
   logic [1:0]      last_idx;
   logic            any_grant;
   logic [15:0]     taken;
   logic [1:0]      scan_idx;
   logic            stalled;

   // Round-robin scan: assign each valid request to the PC slot or the first
   // free general port, skipping any register already granted this cycle.
   always_comb begin
      grant     = '0;
      sel_1     = 2'd0;
      sel_2     = 2'd0;
      sel_pc    = 2'd0;
      use_1     = 1'b0;
      use_2     = 1'b0;
      use_pc    = 1'b0;
      last_idx  = rr_ptr_q;
      any_grant = 1'b0;
      taken     = '0;
      scan_idx  = rr_ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = rr_ptr_q + 2'(k);
         if (bus.req_valid[scan_idx] && !taken[addr_a[scan_idx]]) begin
            if (addr_a[scan_idx] == PC_ADDR) begin
               if (!use_pc) begin
                  use_pc           = 1'b1;
                  sel_pc           = scan_idx;
                  grant[scan_idx]  = 1'b1;
                  taken[PC_ADDR]   = 1'b1;
                  last_idx         = scan_idx;
                  any_grant        = 1'b1;
               end
            end else if (!use_1) begin
               use_1                  = 1'b1;
               sel_1                  = scan_idx;
               grant[scan_idx]        = 1'b1;
               taken[addr_a[scan_idx]] = 1'b1;
               last_idx               = scan_idx;
               any_grant              = 1'b1;
            end else if (!use_2) begin
               use_2                  = 1'b1;
               sel_2                  = scan_idx;
               grant[scan_idx]        = 1'b1;
               taken[addr_a[scan_idx]] = 1'b1;
               last_idx               = scan_idx;
               any_grant              = 1'b1;
            end
         end
      end
   end

   // Ready is suppressed while reset is asserted so nothing transfers then
   assign req_ready     = grant & {NREQ{rst_n}};
   assign bus.req_ready = req_ready;
   assign stalled       = |(bus.req_valid & ~req_ready);

   // Next-state: issue registers, pointer advance and saturating stall count
   always_comb begin
      rr_ptr_d    = any_grant ? (last_idx + 2'd1) : rr_ptr_q;

      wr_en_1_d   = use_1;
      wr_addr_1_d = use_1 ? addr_a[sel_1] : wr_addr_1_q;
      wr_data_1_d = use_1 ? data_a[sel_1] : wr_data_1_q;

      wr_en_2_d   = use_2;
      wr_addr_2_d = use_2 ? addr_a[sel_2] : wr_addr_2_q;
      wr_data_2_d = use_2 ? data_a[sel_2] : wr_data_2_q;

      pc_write_d  = use_pc;
      pc_update_d = use_pc ? data_a[sel_pc] : pc_update_q;

      stall_cnt_d = stall_cnt_q;
      if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset drops any registered-but-unissued write at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= 2'd0;
         wr_en_1_q   <= 1'b0;
         wr_addr_1_q <= 4'd0;
         wr_data_1_q <= '0;
         wr_en_2_q   <= 1'b0;
         wr_addr_2_q <= 4'd0;
         wr_data_2_q <= '0;
         pc_write_q  <= 1'b0;
         pc_update_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         wr_en_1_q   <= wr_en_1_d;
         wr_addr_1_q <= wr_addr_1_d;
         wr_data_1_q <= wr_data_1_d;
         wr_en_2_q   <= wr_en_2_d;
         wr_addr_2_q <= wr_addr_2_d;
         wr_data_2_q <= wr_data_2_d;
         pc_write_q  <= pc_write_d;
         pc_update_q <= pc_update_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.wr_en_1   = wr_en_1_q;
   assign bus.wr_addr_1 = wr_addr_1_q;
   assign bus.wr_data_1 = wr_data_1_q;
   assign bus.wr_en_2   = wr_en_2_q;
   assign bus.wr_addr_2 = wr_addr_2_q;
   assign bus.wr_data_2 = wr_data_2_q;
   assign bus.pc_write  = pc_write_q;
   assign bus.pc_update = pc_update_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: directed scenarios plus a randomized run checked
// against a list-based grant model.
module tb_reg_write_sched;

   localparam int N     = 32;
   localparam int NREQ  = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   reg_write_sched_if #(.N(N), .NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   reg_write_sched #(.N(N), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] v, input logic [15:0] a, input logic [127:0] d);
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.req_data  = d;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(4'h0, 16'h0, 128'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Reference grant: walk requesters from ptr, keep a list of registers
   // already written this cycle, fill PC slot / port 1 / port 2.
   function automatic void model_grant(input logic [3:0] v, input logic [15:0] a, input int ptr,
                                       output logic [3:0] g, output int p1, output int p2,
                                       output int pc, output int nptr);
      int written[$];
      g = 4'h0; p1 = -1; p2 = -1; pc = -1; nptr = ptr;
      for (int k = 0; k < 4; k++) begin
         int i;
         int ad;
         bit dup;
         i = (ptr + k) % 4;
         ad = int'(a[4*i +: 4]);
         dup = 1'b0;
         foreach (written[j]) if (written[j] == ad) dup = 1'b1;
         if (v[i] && !dup) begin
            if (ad == 15) begin
               if (pc < 0) begin pc = i; g[i] = 1'b1; written.push_back(ad); nptr = (i + 1) % 4; end
            end else if (p1 < 0) begin
               p1 = i; g[i] = 1'b1; written.push_back(ad); nptr = (i + 1) % 4;
            end else if (p2 < 0) begin
               p2 = i; g[i] = 1'b1; written.push_back(ad); nptr = (i + 1) % 4;
            end
         end
      end
   endfunction

   task automatic test_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(4'hF, {4'd4, 4'd3, 4'd2, 4'd1}, {32'h44, 32'h33, 32'h22, 32'h11});
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready); else pass_cnt++;
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_en_2, bus.pc_write} !== 3'b000)
         $display("FAIL reset_enables got %b want 000", {bus.wr_en_1, bus.wr_en_2, bus.pc_write}); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.stall_cnt !== 4'd0) $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); else pass_cnt++;
      total_cnt++;
      if ({bus.wr_addr_1, bus.wr_addr_2, bus.wr_data_1, bus.pc_update} !== '0)
         $display("FAIL reset_addr_data got nonzero want 0"); else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0011) $display("FAIL reset_first_grant got %b want 0011", bus.req_ready); else pass_cnt++;
      $display("txn reset: released, ready=%b", bus.req_ready);
   endtask

   task automatic test_round_robin();
      do_reset();
      drive(4'hF, {4'd4, 4'd3, 4'd2, 4'd1}, {32'h44, 32'h33, 32'h22, 32'h11});
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0011) $display("FAIL rr_cycle0 got %b want 0011", bus.req_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b1100) $display("FAIL rr_cycle1 got %b want 1100", bus.req_ready); else pass_cnt++;
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1, bus.wr_en_2, bus.wr_addr_2, bus.wr_data_2} !==
          {1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22})
         $display("FAIL rr_ports0 got a1=%0d a2=%0d want 1 2", bus.wr_addr_1, bus.wr_addr_2); else pass_cnt++;
      total_cnt++;
      if (bus.stall_cnt !== 4'd1) $display("FAIL rr_stall0 got %0d want 1", bus.stall_cnt); else pass_cnt++;
      @(posedge clk);
      #1;
      drive(4'h0, 16'h0, 128'h0);
      @(negedge clk);
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1, bus.wr_en_2, bus.wr_addr_2, bus.wr_data_2} !==
          {1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44})
         $display("FAIL rr_ports1 got a1=%0d a2=%0d want 3 4", bus.wr_addr_1, bus.wr_addr_2); else pass_cnt++;
      $display("txn round_robin: R1/R2 then R3/R4");
   endtask

   task automatic test_same_addr();
      do_reset();
      drive(4'b0101, {4'd0, 4'd5, 4'd0, 4'd5}, {32'h0, 32'hB, 32'h0, 32'hA});
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0001) $display("FAIL same_cycle0 got %b want 0001", bus.req_ready); else pass_cnt++;
      @(posedge clk);
      #1;
      drive(4'b0100, {4'd0, 4'd5, 4'd0, 4'd5}, {32'h0, 32'hB, 32'h0, 32'hA});
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0100) $display("FAIL same_cycle1 got %b want 0100", bus.req_ready); else pass_cnt++;
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1, bus.wr_en_2} !== {1'b1, 4'd5, 32'hA, 1'b0})
         $display("FAIL same_write0 got en1=%b a=%0d d=%h en2=%b want 1 5 a 0",
                  bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1, bus.wr_en_2); else pass_cnt++;
      @(posedge clk);
      #1;
      drive(4'h0, 16'h0, 128'h0);
      @(negedge clk);
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1} !== {1'b1, 4'd5, 32'hB})
         $display("FAIL same_write1 got en1=%b a=%0d d=%h want 1 5 b",
                  bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1); else pass_cnt++;
      $display("txn same_addr: R5 <= a then b");
   endtask

   task automatic test_pc_slot();
      do_reset();
      drive(4'b0111, {4'd0, 4'd7, 4'd15, 4'd3}, {32'h0, 32'h77, 32'h100, 32'h33});
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0111) $display("FAIL pc_ready got %b want 0111", bus.req_ready); else pass_cnt++;
      @(posedge clk);
      #1;
      drive(4'h0, 16'h0, 128'h0);
      @(negedge clk);
      total_cnt++;
      if ({bus.pc_write, bus.pc_update} !== {1'b1, 32'h100})
         $display("FAIL pc_issue got pw=%b pc=%h want 1 100", bus.pc_write, bus.pc_update); else pass_cnt++;
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_en_2, bus.wr_addr_2} !== {1'b1, 4'd3, 1'b1, 4'd7})
         $display("FAIL pc_ports got a1=%0d a2=%0d want 3 7", bus.wr_addr_1, bus.wr_addr_2); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_en_2, bus.pc_write, bus.pc_update} !== {3'b000, 32'h100})
         $display("FAIL pc_one_cycle got en=%b pc=%h want 000 100",
                  {bus.wr_en_1, bus.wr_en_2, bus.pc_write}, bus.pc_update); else pass_cnt++;
      $display("txn pc_slot: three grants in one cycle");
   endtask

   task automatic test_saturation();
      int want;
      do_reset();
      drive(4'b0011, {4'd0, 4'd0, 4'd15, 4'd15}, {32'h0, 32'h0, 32'h2222, 32'h1111});
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         want = (c > 15) ? 15 : c;
         total_cnt++;
         if (bus.stall_cnt !== 4'(want))
            $display("FAIL sat_cycle%0d got %0d want %0d", c, bus.stall_cnt, want); else pass_cnt++;
         total_cnt++;
         if (bus.req_ready !== ((c % 2 == 0) ? 4'b0001 : 4'b0010))
            $display("FAIL sat_ready%0d got %b", c, bus.req_ready); else pass_cnt++;
      end
      @(posedge clk);
      #1;
      drive(4'h0, 16'h0, 128'h0);
      @(negedge clk);
      total_cnt++;
      if (bus.stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d want 15", bus.stall_cnt); else pass_cnt++;
      $display("txn saturation: stall_cnt=%0d", bus.stall_cnt);
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(4'b0001, {12'h0, 4'd9}, {96'h0, 32'h55});
      @(negedge clk);
      total_cnt++;
      if (bus.req_ready !== 4'b0001) $display("FAIL async_grant got %b want 0001", bus.req_ready); else pass_cnt++;
      @(posedge clk);
      #1;
      drive(4'h0, 16'h0, 128'h0);
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1} !== {1'b1, 4'd9})
         $display("FAIL async_issue got en1=%b a=%0d want 1 9", bus.wr_en_1, bus.wr_addr_1); else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1} !== {1'b0, 4'd0, 32'h0})
         $display("FAIL async_drop got en1=%b a=%0d want 0 0", bus.wr_en_1, bus.wr_addr_1); else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("txn async_reset: write dropped");
   endtask

   task automatic test_random(input int ncyc);
      logic [3:0]   v, g;
      logic [15:0]  a;
      logic [127:0] d;
      int ptr, nptr, cnt, p1, p2, pc;
      logic         e1, e2, ep;
      logic [3:0]   ea1, ea2;
      logic [31:0]  ed1, ed2, epc;
      do_reset();
      v = 4'h0; a = 16'h0; d = 128'h0;
      ptr = 0; cnt = 0;
      e1 = 1'b0; e2 = 1'b0; ep = 1'b0;
      ea1 = 4'd0; ea2 = 4'd0; ed1 = 32'h0; ed2 = 32'h0; epc = 32'h0;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!v[i] && ($urandom_range(0, 9) < 7)) begin
               v[i] = 1'b1;
               a[4*i +: 4] = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
               d[32*i +: 32] = $urandom;
            end
         end
         drive(v, a, d);
         model_grant(v, a, ptr, g, p1, p2, pc, nptr);
         @(negedge clk);
         total_cnt++;
         if (bus.req_ready !== g) $display("FAIL rnd_ready c%0d got %b want %b", c, bus.req_ready, g); else pass_cnt++;
         total_cnt++;
         if ({bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1, bus.wr_en_2, bus.wr_addr_2, bus.wr_data_2} !==
             {e1, ea1, ed1, e2, ea2, ed2})
            $display("FAIL rnd_ports c%0d got %b/%0d/%h %b/%0d/%h want %b/%0d/%h %b/%0d/%h", c,
                     bus.wr_en_1, bus.wr_addr_1, bus.wr_data_1, bus.wr_en_2, bus.wr_addr_2, bus.wr_data_2,
                     e1, ea1, ed1, e2, ea2, ed2); else pass_cnt++;
         total_cnt++;
         if ({bus.pc_write, bus.pc_update} !== {ep, epc})
            $display("FAIL rnd_pc c%0d got %b/%h want %b/%h", c, bus.pc_write, bus.pc_update, ep, epc); else pass_cnt++;
         total_cnt++;
         if (bus.stall_cnt !== 4'(cnt)) $display("FAIL rnd_stall c%0d got %0d want %0d", c, bus.stall_cnt, cnt); else pass_cnt++;
         if (bus.wr_en_1 && bus.wr_en_2) begin
            total_cnt++;
            if (bus.wr_addr_1 === bus.wr_addr_2) $display("FAIL rnd_dup_addr c%0d got %0d on both ports", c, bus.wr_addr_1);
            else pass_cnt++;
         end
         $display("txn rnd c%0d valid=%b grant=%b", c, v, g);
         // model commits at the upcoming edge
         if ((v & ~g) != 4'h0 && cnt < 15) cnt++;
         ptr = nptr;
         e1 = (p1 >= 0); e2 = (p2 >= 0); ep = (pc >= 0);
         if (p1 >= 0) begin ea1 = a[4*p1 +: 4]; ed1 = d[32*p1 +: 32]; end
         if (p2 >= 0) begin ea2 = a[4*p2 +: 4]; ed2 = d[32*p2 +: 32]; end
         if (pc >= 0) epc = d[32*pc +: 32];
         v = v & ~g;
         @(posedge clk);
         #1;
      end
      drive(4'h0, 16'h0, 128'h0);
   endtask

   initial begin
      drive(4'h0, 16'h0, 128'h0);
      test_reset();
      test_round_robin();
      test_same_addr();
      test_pc_slot();
      test_saturation();
      test_async_reset();
      test_random(300);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
